// File: rtl/mutual_system.sv
// Murphi "mutual" mutual-exclusion protocol: NUM_PROC processes share one lock, one rule fires per cycle.
// Optional checks are compiled when MUTUAL_ASSERT_EN is defined.
module mutual_system #(
  parameter int unsigned NUM_PROC = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            io_en_a,
  output logic [2*NUM_PROC-1:0] io_n,
  output logic                  io_x,
  output logic                  io_fired,
  output logic                  io_mutex_ok
);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_T = 2'd1;
  localparam logic [1:0] ST_C = 2'd2;
  localparam logic [1:0] ST_E = 2'd3;

  localparam logic [1:0] R_TRY  = 2'd0;
  localparam logic [1:0] R_CRIT = 2'd1;
  localparam logic [1:0] R_EXIT = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd3;

  logic [NUM_PROC-1:0][1:0] n_q, n_d;
  logic                     x_q, x_d;
  logic                     fired_q, fired_d;
  logic [1:0]               rule_id;
  logic [1:0]               proc_id;
  logic [2:0]               crit_cnt;

  assign rule_id = io_en_a[3:2];
  assign proc_id = io_en_a[1:0];

  // Selecting by loop comparison keeps out-of-range process ids a natural no-op.
  always_comb begin
    n_d     = n_q;
    x_d     = x_q;
    fired_d = 1'b0;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      if (proc_id == 2'(i)) begin
        unique case (rule_id)
          R_TRY: begin
            if (n_q[i] == ST_I) begin
              n_d[i]  = ST_T;
              fired_d = 1'b1;
            end
          end
          R_CRIT: begin
            if (n_q[i] == ST_T && x_q) begin
              n_d[i]  = ST_C;
              x_d     = 1'b0;
              fired_d = 1'b1;
            end
          end
          R_EXIT: begin
            if (n_q[i] == ST_C) begin
              n_d[i]  = ST_E;
              fired_d = 1'b1;
            end
          end
          R_IDLE: begin
            if (n_q[i] == ST_E) begin
              n_d[i]  = ST_I;
              x_d     = 1'b1;
              fired_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_q     <= '0;
      x_q     <= 1'b1;
      fired_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      x_q     <= x_d;
      fired_q <= fired_d;
    end
  end

  always_comb begin
    crit_cnt = '0;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      crit_cnt = crit_cnt + {2'b00, (n_q[i] == ST_C)};
    end
  end

  assign io_n        = n_q;
  assign io_x        = x_q;
  assign io_fired    = fired_q;
  assign io_mutex_ok = (crit_cnt <= 3'd1);

`ifdef MUTUAL_ASSERT_EN
  logic [31:0] cyc_q;
  logic        rst_prev_q;

  always_ff @(posedge clock) begin
    cyc_q      <= cyc_q + 32'd1;
    rst_prev_q <= reset;
    if (!reset) begin
      assert (io_mutex_ok)
        else $error("cycle %0d: more than one process in C", cyc_q);
      if (x_q)
        assert (crit_cnt == 3'd0)
          else $error("cycle %0d: lock free while a process is in C", cyc_q);
      if (crit_cnt != 3'd0)
        assert (!x_q)
          else $error("cycle %0d: process in C but lock not held", cyc_q);
      if (rst_prev_q)
        assert (n_q == '0 && x_q)
          else $error("cycle %0d: state not idle after reset release", cyc_q);
    end
  end
`endif

endmodule

// File: tb/tb_mutual_system.sv
// Self-checking bench for mutual_system: directed protocol walk followed by random rule selects vs. a rule-level model.
module tb_mutual_system;

  localparam int NP = 3;

  logic          clock;
  logic          reset;
  logic [3:0]    io_en_a;
  logic [2*NP-1:0] io_n;
  logic          io_x;
  logic          io_fired;
  logic          io_mutex_ok;

  mutual_system #(.NUM_PROC(NP)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_en_a    (io_en_a),
    .io_n       (io_n),
    .io_x       (io_x),
    .io_fired   (io_fired),
    .io_mutex_ok(io_mutex_ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: states as plain integers, 0=idle 1=trying 2=critical 3=exiting.
  int  st [NP];
  bit  lock_free;
  bit  fired_m;
  int  passed;
  int  total;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_step(input bit rst, input int en);
    int r, p;
    r = en / 4;
    p = en % 4;
    fired_m = 0;
    if (rst) begin
      foreach (st[i]) st[i] = 0;
      lock_free = 1;
      return;
    end
    if (p >= NP) return;
    if (r == 0 && st[p] == 0) begin st[p] = 1; fired_m = 1; end
    else if (r == 1 && st[p] == 1 && lock_free) begin st[p] = 2; lock_free = 0; fired_m = 1; end
    else if (r == 2 && st[p] == 2) begin st[p] = 3; fired_m = 1; end
    else if (r == 3 && st[p] == 3) begin st[p] = 0; lock_free = 1; fired_m = 1; end
  endfunction

  function automatic logic [7:0] exp_n();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v = v + 8'(st[i] * (1 << (2 * i)));
    return v;
  endfunction

  function automatic logic [7:0] exp_mutex();
    int c;
    c = 0;
    foreach (st[i]) if (st[i] == 2) c++;
    return (c <= 1) ? 8'd1 : 8'd0;
  endfunction

  task automatic step(input string tag, input bit rst, input logic [3:0] en);
    reset   = rst;
    io_en_a = en;
    model_step(rst, int'(en));
    @(posedge clock);
    #1;
    check({tag, ".n"},     8'(io_n),        exp_n());
    check({tag, ".x"},     8'(io_x),        8'(lock_free));
    check({tag, ".fired"}, 8'(io_fired),    8'(fired_m));
    check({tag, ".mutex"}, 8'(io_mutex_ok), exp_mutex());
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    io_en_a = 4'b1100;
    #2;

    step("reset",        1'b1, 4'b1100);
    step("try_p0",       1'b0, 4'b0000);
    step("crit_p0",      1'b0, 4'b0100);
    step("try_p1",       1'b0, 4'b0001);
    step("crit_p1_blk",  1'b0, 4'b0101);
    step("exit_p0",      1'b0, 4'b1000);
    step("idle_p0",      1'b0, 4'b1100);
    step("crit_p1",      1'b0, 4'b0101);
    step("exit_p0_blk",  1'b0, 4'b1000);
    step("illegal_p3",   1'b0, 4'b0011);
    step("illegal_p3b",  1'b0, 4'b1111);
    step("reset_mid",    1'b1, 4'b1100);
    step("try_after",    1'b0, 4'b0000);
    step("try_again",    1'b0, 4'b0000);

    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mutual_system.md
Name: mutual_system

Overview:
- Synthesizable hardware model of the Murphi "mutual" mutual-exclusion protocol.
- NUM_PROC processes each hold a 2-bit state: I = 0 (idle), T = 1 (trying), C = 2 (critical), E = 3 (exiting). One shared boolean x is the lock, 1 = free.
- Each cycle an external 4-bit enable selects at most one guarded rule instance to fire.
- Top level of the equivalence/formal-checking harness. A formal tool drives io_en_a freely and checks the mutual-exclusion invariant.

Parameters:
- NUM_PROC, 3: number of processes; legal range 1..4; process index is a 2-bit field.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- io_en_a  input  4  rule select: bits [3:2] = rule id, bits [1:0] = process id.
- io_n  output  2*NUM_PROC  concatenated process states; process i occupies bits [2i+1:2i].
- io_x  output  1  current lock value.
- io_fired  output  1  registered; 1 if the rule selected in the previous cycle fired.
- io_mutex_ok  output  1  combinational; 1 when at most one process is in C.

Behaviour:
- State registers: n_reg_0 .. n_reg_{NUM_PROC-1} (2 bits each) and x_reg (1 bit).
- Reset (synchronous, reset = 1 at a rising edge):
  - every n_reg = I, x_reg = 1, io_fired = 0.
  - Reset has priority over any rule; io_en_a is ignored during reset.
- Rule decode: r = io_en_a[3:2], p = io_en_a[1:0].
- If p >= NUM_PROC, the cycle is a no-op: no state change, io_fired = 0 next cycle.
- Rules, evaluated on the current register values; a rule fires only when its guard is true:
  - r = 0, Try: guard n[p] == I; action n[p] := T.
  - r = 1, Crit: guard n[p] == T and x == 1; action n[p] := C, x := 0.
  - r = 2, Exit: guard n[p] == C; action n[p] := E.
  - r = 3, Idle: guard n[p] == E; action n[p] := I, x := 1.
- Guard false: all state is held and io_fired = 0 on the next cycle.
- At most one rule fires per cycle, so there are no simultaneous-write conflicts.
- Latency: the new state is visible on io_n / io_x one cycle after io_en_a is applied.
- io_fired is registered alongside the state update.
- io_mutex_ok: combinational count of processes with n == C; asserted when the count <= 1.
  - From reset, reachable states always keep it 1.
  - Unreachable states forced by a formal tool (e.g. two processes in C) must drive it 0.
- Processes not addressed by p are never modified.
- No wrap-around arithmetic. States are assigned only as explicit constants.

Optional Feature:
- Macro MUTUAL_ASSERT_EN.
- When defined, the block contains simulation/formal checks, each reported with an error message naming the cycle:
  - assert io_mutex_ok every cycle when not in reset;
  - assert x_reg == 1 implies no process is in C;
  - when any process is in C, x_reg == 0;
  - on the cycle after reset is released, all n == I and x == 1.
- When undefined, no checks are compiled. Ports and functional behaviour are identical.

Test Plan:
- Reset for 1 cycle with io_en_a = 4'b1100 -> io_n = 0, io_x = 1, io_fired = 0. The Idle rule on p0 is ignored.
- Try p0 (4'b0000), then Crit p0 (4'b0100) -> n0 goes T then C, io_x = 0, io_fired = 1 on both cycles.
- With p0 in C: Try p1 (4'b0001), then Crit p1 (4'b0101) -> n1 = T stays T, io_fired = 0, io_mutex_ok = 1.
- Exit p0 (4'b1000), then Idle p0 (4'b1100) -> n0 = E then I, io_x = 1. A following Crit p1 moves n1 to C.
- Guard-false and illegal selects: io_en_a = 4'b1000 with n0 = I, and io_en_a = 4'b0011 (p = 3, NUM_PROC = 3) -> no state change, io_fired = 0.
- Force n_reg_1 = C, x_reg = 0, then apply reset with io_en_a = 4'b1100, then hold io_en_a = 4'b0000 for 2 cycles -> after reset all I and x = 1; then n0 = T, then n0 stays T (Try guard false). io_mutex_ok = 1 throughout, no assertion fires with MUTUAL_ASSERT_EN defined.
